// File: rtl/bcd_scan_display_if.sv
// bcd_scan_display_if: digit load/enable inputs and scanned an/seg/frame_done outputs of the display driver
interface bcd_scan_display_if;
  logic load;
  logic enable;
  logic [3:0] mille;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] an;
  logic [6:0] seg;
  logic frame_done;
  modport master(output load, enable, mille, hundreds, tens, ones, input an, seg, frame_done);
  modport slave(input load, enable, mille, hundreds, tens, ones, output an, seg, frame_done);
endinterface

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: multiplexed 4-digit 7-segment driver scanning latched BCD digits
// Define BCD_SCAN_LZB_EN to blank leading zeros on digits 3..1.
module bcd_scan_display #(
  parameter int CLK_DIV = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic clock,
  input logic reset,
  bcd_scan_display_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [3:0] AN_OFF = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [3:0][3:0] dig;
  logic tick;
  logic wrap;
  logic blank;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'h3F;
      4'd1: dec = 7'h06;
      4'd2: dec = 7'h5B;
      4'd3: dec = 7'h4F;
      4'd4: dec = 7'h66;
      4'd5: dec = 7'h6D;
      4'd6: dec = 7'h7D;
      4'd7: dec = 7'h07;
      4'd8: dec = 7'h7F;
      4'd9: dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  endfunction
  assign tick = cnt == CW'(CLK_DIV - 1);
  always_comb begin
`ifdef BCD_SCAN_LZB_EN
    blank = idx == 2'd3 ? dig[3] == 4'd0 :
            idx == 2'd2 ? dig[3:2] == 8'd0 :
            idx == 2'd1 ? dig[3:1] == 12'd0 : 1'b0;
`else
    blank = 1'b0;
`endif
    an_n = bus.enable ? 4'b1 << idx : 4'b0;
    seg_n = bus.enable && !blank ? dec(dig[idx]) : 7'b0;
  end
  // wrap marks the first cycle of a new frame; frame_done lags it to line up with the an update
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      dig <= '0;
      wrap <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.an <= AN_OFF;
      bus.seg <= SEG_OFF;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      idx <= idx + 2'(tick);
      wrap <= tick && idx == 2'd3;
      bus.frame_done <= wrap;
      bus.an <= an_n ^ AN_OFF;
      bus.seg <= seg_n ^ SEG_OFF;
      if (bus.load) dig <= {bus.mille, bus.hundreds, bus.tens, bus.ones};
    end
  end
endmodule
